h_bridge_driver: RTL and testbench
==================================

# h_bridge_driver

Output stage between the movement controllers (forward/reverse/turn logic) and the dual H-bridge motor pins. Takes the 4-bit IN request word those stages produce, enforces a dead-time on every exit from a drive direction, and generates the ENA/ENB PWM from a shared duty value. The applied IN word is returned as `presentINs`, so upstream stages always see what the bridge is actually doing.

## Interface
- `DEAD_CYCLES`, 5000: clock cycles that a channel holds IN=00 and EN=0 on leaving DRIVE (100 µs at 50 MHz); minimum 1.
- `PWM_DIV`, 10: clocks per PWM counter step; minimum 1. PWM period = 256·PWM_DIV clocks.
- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  global motion permit (canMove). Low forces both channels toward coast.
- `requestINs`  in  4  {IN1,IN2} = left channel, {IN3,IN4} = right channel. Per channel: 10 = forward, 01 = reverse, 00 = coast, 11 = brake.
- `duty`  in  8  PWM duty, 0..255, applied to both channels.
- `hbridgeINs`  out  4  IN pins to the bridge, registered.
- `ENA`, `ENB`  out  1 each  enable/PWM pins for left and right, registered.
- `presentINs`  out  4  equal to `hbridgeINs`; feedback to the movement stages.
- `busy`  out  1  high while either channel is in DEADTIME.

## Operation
- `requestINs` and `enable` are registered once into req_q/en_q. Each channel FSM acts on its 2-bit slice of req_q.
- Effective request: req_q slice if en_q=1, otherwise 00.
- States per channel: IDLE (IN=00, EN=0), DRIVE (IN=FWD or REV, EN=pwm), BRAKE (IN=11, EN=1), DEADTIME (IN=00, EN=0).
- IDLE: FWD/REV → DRIVE with that direction. 11 → BRAKE. 00 → stay.
- BRAKE: FWD/REV → DRIVE. 00 → IDLE. 11 → stay.
- DRIVE: the same direction → stay. Any other request (opposite direction, coast, brake, or disable) → DEADTIME, with the counter loaded to DEAD_CYCLES−1.
- DEADTIME: decrements each cycle. At 0 it applies the effective request present in that cycle (DRIVE, BRAKE or IDLE). The counter cannot be aborted or extended by request changes.
- PWM: one shared 8-bit counter, advanced once every PWM_DIV clocks and wrapping 255→0. `duty` is latched into duty_q only when the counter wraps to 0.
- The channel EN in DRIVE is (cnt < duty_q). duty_q=0 gives EN always low. duty_q=255 gives EN low one step per period.
- `busy` = OR of both channels' DEADTIME state, registered together with the outputs.

## Timing
- Reset (asynchronous, low): `hbridgeINs`=0000, `presentINs`=0000, ENA=ENB=0, `busy`=0, both FSMs IDLE, the dead-time counters, PWM counter and prescaler all 0, duty_q=0, req_q=0000, en_q=0.
- Request latency: a change on `requestINs` sampled at edge N appears on `hbridgeINs` after edge N+1 (two edges), when no dead-time applies.
- Dead-time: the cycle after the exit decision, IN=00 and EN=0 are held for exactly DEAD_CYCLES clocks. The next state's outputs appear on the following edge.
- Reset mid-DEADTIME: the channel goes IDLE immediately. After reset is released, a drive request is applied without dead-time, because the outputs were already 00 during reset.
- Simultaneous events: the two channels are independent. A duty change and a PWM wrap on the same edge use the new duty from counter value 0.
- After a disable, the first re-enable with any request is still subject to any DEADTIME that is in progress.

## Structure
- Package `hbridge_pkg` holds:
  - the channel state enum (IDLE, DRIVE, BRAKE, DEADTIME);
  - the direction codes DIR_COAST=2'b00, DIR_REV=2'b01, DIR_FWD=2'b10, DIR_BRAKE=2'b11.
- Sub-module `hbridge_channel` is instantiated twice. It contains the FSM, the dead-time counter and the output registers, and takes pwm_on from the top level.
- The top level holds the input registers, the prescaler, the PWM counter, duty_q and `busy`.

## Test plan
All scenarios use DEAD_CYCLES=4 and PWM_DIV=1.
- Reset: hold reset_n=0 with requestINs=1010 and duty=128. Required: all outputs 0. Release with enable=1: hbridgeINs=1010 two edges later, busy=0.
- Reversal: from steady 1010, request 0101. Required: hbridgeINs=0000 and busy=1 for exactly 4 clocks, then 0101, then busy=0. presentINs tracks hbridgeINs on every cycle.
- PWM: steady 1010 with duty=64. Required: ENA high for 64 of every 256 clocks. Change duty to 192 mid-period: the new ratio starts at the next wrap. duty=0 gives ENA constantly 0.
- Brake and coast: from IDLE, request 1100. Required: left channel IN=11 with ENA=1, immediately, with no dead-time. From left forward, request 00xx: 4 clocks of dead-time, then IDLE.
- Disable while driving: enable dropped for 1 cycle during 0110, then re-enabled with 1001. Required: a 4-clock dead-time on both channels, then 1001.
- Reset during DEADTIME: assert reset_n=0 at dead-time count 2. Required: outputs 0 immediately. On release with 0101: 0101 two edges later.

Source files
------------

// File: rtl/hbridge_pkg.sv
// Shared types and direction codes for the H-bridge output stage.
package hbridge_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StBrake,
        StDead
    } ch_state_e;

    localparam logic [1:0] DIR_COAST = 2'b00;
    localparam logic [1:0] DIR_REV   = 2'b01;
    localparam logic [1:0] DIR_FWD   = 2'b10;
    localparam logic [1:0] DIR_BRAKE = 2'b11;

    // True for the two codes that actually push current through the motor.
    function automatic logic is_drive(input logic [1:0] dir);
        return (dir == DIR_FWD) || (dir == DIR_REV);
    endfunction

endpackage

// File: rtl/h_bridge_driver_if.sv
// Request/feedback bundle between the movement stages and the bridge driver.
interface h_bridge_driver_if;

    logic       enable;
    logic [3:0] requestINs;
    logic [7:0] duty;
    logic [3:0] hbridgeINs;
    logic       ENA;
    logic       ENB;
    logic [3:0] presentINs;
    logic       busy;

    modport master (
        output enable, requestINs, duty,
        input  hbridgeINs, ENA, ENB, presentINs, busy
    );

    modport slave (
        input  enable, requestINs, duty,
        output hbridgeINs, ENA, ENB, presentINs, busy
    );

endinterface

// File: rtl/hbridge_channel.sv
// One bridge channel: state machine, dead-time counter and registered IN/EN pins.
module hbridge_channel
    import hbridge_pkg::*;
#(
    parameter int unsigned DEAD_CYCLES = 5000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       pwm_on_i,
    output logic [1:0] in_o,
    output logic       en_o,
    output logic       dead_o
);

    localparam int unsigned CntW = $clog2(DEAD_CYCLES + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(DEAD_CYCLES - 1);

    ch_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      in_q, in_d;
    logic            en_q, en_d;

    // Next state, dead-time count and the pin values for that next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        in_d    = DIR_COAST;
        en_d    = 1'b0;

        unique case (state_q)
            StIdle, StBrake: begin
                if (is_drive(req_i)) begin
                    state_d = StDrive;
                end else if (req_i == DIR_BRAKE) begin
                    state_d = StBrake;
                end else begin
                    state_d = StIdle;
                end
            end
            StDrive: begin
                // in_q holds the direction being driven.
                if (req_i != in_q) begin
                    state_d = StDead;
                    cnt_d   = CntLoad;
                end
            end
            StDead: begin
                if (cnt_q == '0) begin
                    if (is_drive(req_i)) begin
                        state_d = StDrive;
                    end else if (req_i == DIR_BRAKE) begin
                        state_d = StBrake;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        unique case (state_d)
            StDrive: begin
                in_d = req_i;
                en_d = pwm_on_i;
            end
            StBrake: begin
                in_d = DIR_BRAKE;
                en_d = 1'b1;
            end
            default: begin
                in_d = DIR_COAST;
                en_d = 1'b0;
            end
        endcase
    end

    // Channel state and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            in_q    <= DIR_COAST;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            in_q    <= in_d;
            en_q    <= en_d;
        end
    end

    assign in_o   = in_q;
    assign en_o   = en_q;
    assign dead_o = (state_d == StDead);

endmodule

// File: rtl/h_bridge_driver.sv
// Dual H-bridge output stage: input registers, shared PWM and two channel FSMs.
module h_bridge_driver
    import hbridge_pkg::*;
#(
    parameter int unsigned DEAD_CYCLES = 5000,
    parameter int unsigned PWM_DIV     = 10
) (
    input logic              clock,
    input logic              reset_n,
    h_bridge_driver_if.slave bus
);

    localparam int unsigned PreW = $clog2(PWM_DIV + 1);
    localparam logic [PreW-1:0] PreLast = PreW'(PWM_DIV - 1);

    logic [3:0]      req_q, req_d;
    logic            en_q, en_d;
    logic [PreW-1:0] presc_q, presc_d;
    logic [7:0]      pwm_cnt_q, pwm_cnt_d;
    logic [7:0]      duty_q, duty_d;
    logic            busy_q, busy_d;

    logic       pwm_on;
    logic [1:0] eff_l, eff_r;
    logic [1:0] in_l, in_r;
    logic       en_l, en_r;
    logic       dead_l, dead_r;

    // Input capture, prescaler and PWM counter; duty only changes on a wrap to 0.
    always_comb begin
        req_d     = bus.requestINs;
        en_d      = bus.enable;
        presc_d   = presc_q + PreW'(1);
        pwm_cnt_d = pwm_cnt_q;
        duty_d    = duty_q;
        busy_d    = dead_l | dead_r;
        if (presc_q == PreLast) begin
            presc_d   = '0;
            pwm_cnt_d = pwm_cnt_q + 8'd1;
            if (pwm_cnt_q == 8'hFF) begin
                duty_d = bus.duty;
            end
        end
    end

    // Top-level registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_q     <= '0;
            en_q      <= 1'b0;
            presc_q   <= '0;
            pwm_cnt_q <= '0;
            duty_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            req_q     <= req_d;
            en_q      <= en_d;
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
            duty_q    <= duty_d;
            busy_q    <= busy_d;
        end
    end

    assign pwm_on = (pwm_cnt_q < duty_q);
    assign eff_l  = en_q ? req_q[3:2] : DIR_COAST;
    assign eff_r  = en_q ? req_q[1:0] : DIR_COAST;

    hbridge_channel #(
        .DEAD_CYCLES(DEAD_CYCLES)
    ) u_left (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .req_i   (eff_l),
        .pwm_on_i(pwm_on),
        .in_o    (in_l),
        .en_o    (en_l),
        .dead_o  (dead_l)
    );

    hbridge_channel #(
        .DEAD_CYCLES(DEAD_CYCLES)
    ) u_right (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .req_i   (eff_r),
        .pwm_on_i(pwm_on),
        .in_o    (in_r),
        .en_o    (en_r),
        .dead_o  (dead_r)
    );

    assign bus.hbridgeINs = {in_l, in_r};
    assign bus.presentINs = {in_l, in_r};
    assign bus.ENA        = en_l;
    assign bus.ENB        = en_r;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_h_bridge_driver.sv
// Bench for h_bridge_driver: output-level reference model plus directed scenarios.
module tb_h_bridge_driver;

    localparam int unsigned DC = 4;
    localparam int unsigned PD = 1;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    h_bridge_driver_if bus ();

    h_bridge_driver #(
        .DEAD_CYCLES(DC),
        .PWM_DIV    (PD)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    logic cmp_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (works on applied outputs, not states) ----
    logic [3:0] m_req;
    logic       m_en;
    logic [1:0] m_out_l, m_out_r;
    int         m_hold_l, m_hold_r;
    logic       m_ena, m_enb, m_busy;
    int         m_t;
    logic [7:0] m_dq;
    logic [1:0] eff_l, eff_r;
    logic       pwm_bit;

    assign eff_l   = m_en ? m_req[3:2] : 2'b00;
    assign eff_r   = m_en ? m_req[1:0] : 2'b00;
    assign pwm_bit = ((m_t / int'(PD)) % 256) < int'(m_dq);

    function automatic logic is_drv(input logic [1:0] d);
        return (d == 2'b10) || (d == 2'b01);
    endfunction

    // Output pins are forced to 00 for DC clocks when a driven direction is left.
    function automatic logic [1:0] nxt_out(input logic [1:0] o, input int h, input logic [1:0] r);
        if (h > 0) return (h == 1) ? r : 2'b00;
        if (is_drv(o) && r != o) return 2'b00;
        return r;
    endfunction

    function automatic int nxt_hold(input logic [1:0] o, input int h, input logic [1:0] r);
        if (h > 0) return h - 1;
        if (is_drv(o) && r != o) return int'(DC);
        return 0;
    endfunction

    function automatic logic pin(input logic [1:0] o, input logic p);
        if (o == 2'b11) return 1'b1;
        if (is_drv(o)) return p;
        return 1'b0;
    endfunction

    initial begin
        m_req = '0; m_en = 0; m_out_l = '0; m_out_r = '0; m_hold_l = 0; m_hold_r = 0;
        m_ena = 0; m_enb = 0; m_busy = 0; m_t = 0; m_dq = '0;
    end

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_req <= '0; m_en <= 1'b0;
            m_out_l <= '0; m_out_r <= '0; m_hold_l <= 0; m_hold_r <= 0;
            m_ena <= 1'b0; m_enb <= 1'b0; m_busy <= 1'b0;
            m_t <= 0; m_dq <= '0;
        end else begin
            m_out_l  <= nxt_out(m_out_l, m_hold_l, eff_l);
            m_out_r  <= nxt_out(m_out_r, m_hold_r, eff_r);
            m_hold_l <= nxt_hold(m_out_l, m_hold_l, eff_l);
            m_hold_r <= nxt_hold(m_out_r, m_hold_r, eff_r);
            m_ena    <= pin(nxt_out(m_out_l, m_hold_l, eff_l), pwm_bit);
            m_enb    <= pin(nxt_out(m_out_r, m_hold_r, eff_r), pwm_bit);
            m_busy   <= (nxt_hold(m_out_l, m_hold_l, eff_l) != 0) ||
                        (nxt_hold(m_out_r, m_hold_r, eff_r) != 0);
            m_t      <= m_t + 1;
            if (((m_t + 1) % int'(256 * PD)) == 0) m_dq <= bus.duty;
            m_req    <= bus.requestINs;
            m_en     <= bus.enable;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clock) begin
        if (cmp_on) begin
            chk("model_hbridgeINs", 32'(bus.hbridgeINs), 32'({m_out_l, m_out_r}));
            chk("model_presentINs", 32'(bus.presentINs), 32'({m_out_l, m_out_r}));
            chk("model_ENA", 32'(bus.ENA), 32'(m_ena));
            chk("model_ENB", 32'(bus.ENB), 32'(m_enb));
            chk("model_busy", 32'(bus.busy), 32'(m_busy));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic count_ena(input int n, output int hi);
        hi = 0;
        repeat (n) begin
            @(negedge clock);
            if (bus.ENA === 1'b1) hi++;
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int hi;
        bus.enable     = 1'b1;
        bus.requestINs = 4'b1010;
        bus.duty       = 8'd128;
        #1 reset_n = 1'b0;
        #1 cmp_on = 1'b1;

        // Reset
        tick(3);
        chk("reset_hbridgeINs", 32'(bus.hbridgeINs), 32'h0);
        chk("reset_ENA_ENB", 32'({bus.ENA, bus.ENB}), 32'h0);
        chk("reset_busy", 32'(bus.busy), 32'h0);
        reset_n = 1'b1;
        tick(1);
        chk("release_edge1", 32'(bus.hbridgeINs), 32'h0);
        tick(1);
        chk("release_edge2", 32'(bus.hbridgeINs), 32'hA);
        chk("release_busy", 32'(bus.busy), 32'h0);

        // Reversal 1010 -> 0101
        tick(5);
        bus.requestINs = 4'b0101;
        tick(1);
        chk("rev_before", 32'(bus.hbridgeINs), 32'hA);
        for (int i = 0; i < int'(DC); i++) begin
            tick(1);
            chk("rev_dead_in", 32'(bus.hbridgeINs), 32'h0);
            chk("rev_dead_busy", 32'(bus.busy), 32'h1);
        end
        tick(1);
        chk("rev_after_in", 32'(bus.hbridgeINs), 32'h5);
        chk("rev_after_busy", 32'(bus.busy), 32'h0);

        // PWM
        bus.requestINs = 4'b1010;
        bus.duty       = 8'd64;
        tick(520);
        count_ena(256, hi);
        chk("pwm_duty64", 32'(hi), 32'd64);
        tick(100);
        bus.duty = 8'd192;
        tick(520);
        count_ena(256, hi);
        chk("pwm_duty192", 32'(hi), 32'd192);
        bus.duty = 8'd0;
        tick(520);
        count_ena(256, hi);
        chk("pwm_duty0", 32'(hi), 32'd0);
        bus.duty = 8'd128;

        // Brake and coast
        bus.requestINs = 4'b0000;
        tick(10);
        bus.requestINs = 4'b1100;
        tick(2);
        chk("brake_in", 32'(bus.hbridgeINs), 32'hC);
        chk("brake_ena", 32'(bus.ENA), 32'h1);
        chk("brake_busy", 32'(bus.busy), 32'h0);
        bus.requestINs = 4'b1000;
        tick(2);
        chk("brake_to_fwd", 32'(bus.hbridgeINs), 32'h8);
        bus.requestINs = 4'b0000;
        tick(1);
        for (int i = 0; i < int'(DC); i++) begin
            tick(1);
            chk("coast_dead_busy", 32'(bus.busy), 32'h1);
        end
        tick(1);
        chk("coast_idle_in", 32'(bus.hbridgeINs), 32'h0);
        chk("coast_idle_busy", 32'(bus.busy), 32'h0);

        // Disable while driving
        bus.requestINs = 4'b0110;
        tick(10);
        chk("dis_steady", 32'(bus.hbridgeINs), 32'h6);
        bus.enable = 1'b0;
        tick(1);
        chk("dis_before", 32'(bus.hbridgeINs), 32'h6);
        bus.enable     = 1'b1;
        bus.requestINs = 4'b1001;
        for (int i = 0; i < int'(DC); i++) begin
            tick(1);
            chk("dis_dead_in", 32'(bus.hbridgeINs), 32'h0);
            chk("dis_dead_busy", 32'(bus.busy), 32'h1);
        end
        tick(1);
        chk("dis_after", 32'(bus.hbridgeINs), 32'h9);

        // Reset during dead-time
        tick(5);
        bus.requestINs = 4'b0110;
        tick(3);
        chk("rst_dead_busy", 32'(bus.busy), 32'h1);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_async_in", 32'(bus.hbridgeINs), 32'h0);
        chk("rst_async_busy", 32'(bus.busy), 32'h0);
        bus.requestINs = 4'b0101;
        tick(2);
        reset_n = 1'b1;
        tick(1);
        chk("rst_rel_edge1", 32'(bus.hbridgeINs), 32'h0);
        tick(1);
        chk("rst_rel_edge2", 32'(bus.hbridgeINs), 32'h5);
        chk("rst_rel_busy", 32'(bus.busy), 32'h0);
        tick(3);

        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
